// File: rtl/spi_master_shifter.sv
// SPI master data path: frames cs_n, shifts MOSI/MISO on the generator's edge
// pulses, and exchanges one byte per transaction with the host over valid/ready.
module spi_master_shifter #(
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       cpol_in,
  input  logic       cpha_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       tx_dp,
  output logic       cpol_o,
  output logic       cpha_o,
  input  logic       sampling_edge,
  input  logic       toggling_edge,
  input  logic       miso,
  output logic       mosi,
  output logic       cs_n
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);

  logic [1:0] state;
  logic [3:0] phase_cnt;
  logic [4:0] edge_cnt;
  logic [4:0] edge_cnt_nxt;
  logic [4:0] tog_idx;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic       accept;

  // The completion cycle keeps tx_ready low so the host sees rx_valid first.
  assign tx_ready     = (state == IDLE) && !rx_valid;
  assign busy         = (state != IDLE);
  assign accept       = tx_valid && tx_ready;
  assign edge_cnt_nxt = edge_cnt + {4'd0, sampling_edge} + {4'd0, toggling_edge};
  // Ordinal of a toggling edge; a coincident sampling edge is counted first.
  assign tog_idx      = edge_cnt + {4'd0, sampling_edge} + 5'd1;

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // the shift registers are plain flops, so they are cleared with the rest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_cnt <= 4'd0;
      edge_cnt  <= 5'd0;
      tx_sr     <= 8'd0;
      rx_sr     <= 8'd0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      tx_dp     <= 1'b0;
      cpol_o    <= 1'b0;
      cpha_o    <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= 1'b1;
    end else begin
      tx_dp    <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SETUP;
            cs_n      <= 1'b0;
            tx_sr     <= tx_data;
            cpol_o    <= cpol_in;
            cpha_o    <= cpha_in;
            phase_cnt <= 4'd0;
            edge_cnt  <= 5'd0;
            if (!cpha_in) mosi <= tx_data[7];
          end
        end
        SETUP: begin
          if (phase_cnt == SETUP_LAST) begin
            tx_dp     <= 1'b1;
            state     <= XFER;
            phase_cnt <= 4'd0;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        XFER: begin
          if (sampling_edge) rx_sr <= {rx_sr[6:0], miso};
          if (toggling_edge) begin
            if (cpha_o) begin
              mosi  <= tx_sr[7];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end else if (tog_idx < 5'd16) begin
              // Bit 7 went out at accept, so even edges present bits 6..0.
              mosi  <= tx_sr[6];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end
          end
          edge_cnt <= edge_cnt_nxt;
          if (edge_cnt_nxt >= 5'd16) begin
            state     <= HOLD;
            phase_cnt <= 4'd0;
          end
        end
        HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
            cs_n     <= 1'b1;
            state    <= IDLE;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: a behavioural clock-generator model feeds edge
// pulses, and a queue of expected received words is checked against rx_valid.
module tb_spi_master_shifter;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int GAP      = 2;                       // idle clks between edges
  localparam int XFER_CYC = 16 * (GAP + 1) + 1;      // tx_dp cycle to 16th edge
  localparam int CS_LOW   = CS_SETUP + XFER_CYC + CS_HOLD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       cpol_in;
  logic       cpha_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       tx_dp;
  logic       cpol_o;
  logic       cpha_o;
  logic       sampling_edge;
  logic       toggling_edge;
  logic       miso;
  logic       mosi;
  logic       cs_n;

  int total = 0;
  int bad   = 0;

  // Generator model state
  logic       loopback = 1'b1;
  logic [7:0] miso_pat = 8'h00;
  logic       stray_req = 1'b0;
  int         stray_cnt = 0;
  logic [7:0] mosi_cap = 8'h00;
  logic       mosi_at_dp = 1'b0;
  int         samp_cnt = 0;
  int         xfer_started = 0;
  int         mosi_bad = 0;

  // Monitor state
  logic [7:0] exp_q[$];
  int rx_count = 0;
  int low_run = 0;
  int high_run = 0;
  int last_low_len = 0;
  int setup_len = 0;
  int min_gap = 1000;
  int fall_cnt = 0;
  int ready_bad = 0;

  always #5 clk = ~clk;

  spi_master_shifter #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpol_in(cpol_in), .cpha_in(cpha_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .tx_dp(tx_dp), .cpol_o(cpol_o), .cpha_o(cpha_o),
    .sampling_edge(sampling_edge), .toggling_edge(toggling_edge),
    .miso(miso), .mosi(mosi), .cs_n(cs_n)
  );

  // Clock-generator model: 16 alternating edge pulses after each tx_dp.
  task automatic run_edges();
    logic ph;
    logic prev_mosi;
    logic prev_tog;
    int   e;
    ph = cpha_o;
    xfer_started++;
    mosi_at_dp = mosi;
    mosi_cap = 8'h00;
    samp_cnt = 0;
    prev_mosi = mosi;
    prev_tog = 1'b0;
    e = 0;
    for (int c = 0; c < 16 * (GAP + 1); c++) begin
      @(negedge clk);
      sampling_edge = 1'b0;
      toggling_edge = 1'b0;
      if (!rst_n) break;
      if (mosi !== prev_mosi && !prev_tog) mosi_bad++;
      prev_mosi = mosi;
      if (c % (GAP + 1) == GAP) begin
        e++;
        if (ph ? (e % 2 == 0) : (e % 2 == 1)) begin
          miso = loopback ? mosi : miso_pat[7 - samp_cnt];
          mosi_cap = {mosi_cap[6:0], mosi};
          samp_cnt++;
          sampling_edge = 1'b1;
        end else begin
          toggling_edge = 1'b1;
        end
      end
      prev_tog = toggling_edge;
    end
  endtask

  initial begin : gen
    sampling_edge = 1'b0;
    toggling_edge = 1'b0;
    miso = 1'b0;
    forever begin
      @(negedge clk);
      sampling_edge = 1'b0;
      toggling_edge = 1'b0;
      if (tx_dp === 1'b1 && rst_n === 1'b1) begin
        run_edges();
      end else if (stray_req && stray_cnt < 6) begin
        sampling_edge = (stray_cnt % 2 == 0);
        toggling_edge = (stray_cnt % 3 == 0);
        stray_cnt++;
      end
    end
  end

  // Scoreboard and framing monitor, sampled on the falling edge.
  initial begin : mon
    logic [7:0] exp_v;
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        rx_count++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rx_unexpected rx_data=%h with no word outstanding", rx_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (rx_data !== exp_v) begin
            bad++;
            $display("FAIL rx_data got=%h want=%h", rx_data, exp_v);
          end
        end
        if (tx_ready === 1'b1) ready_bad++;
      end
      if (cs_n === 1'b0) begin
        if (high_run > 0) begin
          fall_cnt++;
          if (high_run < min_gap) min_gap = high_run;
        end
        high_run = 0;
        low_run++;
        if (tx_ready === 1'b1 || busy !== 1'b1) ready_bad++;
        if (tx_dp === 1'b1) setup_len = low_run - 1;
      end else begin
        if (low_run > 0) last_low_len = low_run;
        low_run = 0;
        high_run++;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic pol, input logic pha,
                      input logic expect_rx, input logic [7:0] exp_v);
    @(negedge clk);
    tx_data = d;
    cpol_in = pol;
    cpha_in = pha;
    tx_valid = 1'b1;
    if (expect_rx) exp_q.push_back(exp_v);
    for (int i = 0; i < 400 && tx_ready !== 1'b1; i++) @(negedge clk);
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_accept tx_ready=%b want 1", tx_ready);
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int target, input string name);
    for (int i = 0; i < 600 && rx_count < target; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++;
    if (rx_count != target) begin
      bad++;
      $display("FAIL %s rx_valid_count got=%0d want=%0d", name, rx_count, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_ready, busy, tx_dp, rx_valid, cs_n, mosi, cpol_o, cpha_o} !== 8'b1000_1000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=10001000",
               {tx_ready, busy, tx_dp, rx_valid, cs_n, mosi, cpol_o, cpha_o});
    end
    total++;
    if (rx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_rx_data got=%h want=00", rx_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0();
    int rx0;
    int mb0;
    rx0 = rx_count;
    mb0 = mosi_bad;
    loopback = 1'b1;
    send(8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5);
    wait_rx(rx0 + 1, "mode0");
    total++;
    if (mosi_at_dp !== 1'b1) begin
      bad++;
      $display("FAIL mode0_bit7_before_tx_dp mosi=%b want 1", mosi_at_dp);
    end
    total++;
    if (mosi_cap !== 8'hA5) begin
      bad++;
      $display("FAIL mode0_mosi_seq got=%h want=a5", mosi_cap);
    end
    total++;
    if (last_low_len != CS_LOW || setup_len != CS_SETUP) begin
      bad++;
      $display("FAIL mode0_cs_frame low=%0d want %0d setup=%0d want %0d",
               last_low_len, CS_LOW, setup_len, CS_SETUP);
    end
    total++;
    if (mosi_bad != mb0) begin
      bad++;
      $display("FAIL mode0_mosi_off_toggle count=%0d want 0", mosi_bad - mb0);
    end
  endtask

  task automatic test_stray_edges();
    int rx0;
    int xs0;
    rx0 = rx_count;
    total++;
    if (mosi !== 1'b1) begin
      bad++;
      $display("FAIL idle_mosi_hold mosi=%b want 1", mosi);
    end
    stray_req = 1'b1;
    for (int i = 0; i < 20 && stray_cnt < 6; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    stray_req = 1'b0;
    total++;
    if ({cs_n, tx_ready, busy, tx_dp, mosi, rx_valid} !== 6'b110010) begin
      bad++;
      $display("FAIL stray_idle got=%b want=110010",
               {cs_n, tx_ready, busy, tx_dp, mosi, rx_valid});
    end
    xs0 = xfer_started;
    loopback = 1'b1;
    send(8'h81, 1'b0, 1'b0, 1'b1, 8'h81);
    for (int i = 0; i < 50 && xfer_started == xs0; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpol_in = ~cpol_in;
    end
    total++;
    if (cpol_o !== 1'b0 || cpha_o !== 1'b0) begin
      bad++;
      $display("FAIL cpol_ignored_in_xfer cpol_o=%b cpha_o=%b want 0 0", cpol_o, cpha_o);
    end
    wait_rx(rx0 + 1, "stray_then_0x81");
    total++;
    if (mosi_cap !== 8'h81) begin
      bad++;
      $display("FAIL x81_mosi_seq got=%h want=81", mosi_cap);
    end
  endtask

  task automatic test_mode3();
    int rx0;
    int mb0;
    rx0 = rx_count;
    mb0 = mosi_bad;
    loopback = 1'b0;
    miso_pat = 8'hC3;
    send(8'h3C, 1'b1, 1'b1, 1'b1, 8'hC3);
    total++;
    if (cpol_o !== 1'b1 || cpha_o !== 1'b1) begin
      bad++;
      $display("FAIL mode3_latched cpol_o=%b cpha_o=%b want 1 1", cpol_o, cpha_o);
    end
    wait_rx(rx0 + 1, "mode3");
    total++;
    if (mosi_cap !== 8'h3C) begin
      bad++;
      $display("FAIL mode3_mosi_seq got=%h want=3c", mosi_cap);
    end
    total++;
    if (mosi_bad != mb0) begin
      bad++;
      $display("FAIL mode3_mosi_off_toggle count=%0d want 0", mosi_bad - mb0);
    end
  endtask

  task automatic test_back_to_back();
    int rx0;
    int f0;
    int rb0;
    rx0 = rx_count;
    f0 = fall_cnt;
    rb0 = ready_bad;
    min_gap = 1000;
    loopback = 1'b1;
    @(negedge clk);
    tx_data = 8'h01;
    cpol_in = 1'b0;
    cpha_in = 1'b0;
    tx_valid = 1'b1;
    exp_q.push_back(8'h01);
    for (int i = 0; i < 50 && tx_ready !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    tx_data = 8'hFF;
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 400 && tx_ready !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    wait_rx(rx0 + 2, "back_to_back");
    total++;
    if (fall_cnt - f0 != 2 || min_gap < 1) begin
      bad++;
      $display("FAIL b2b_frames cs_falls=%0d want 2 min_gap=%0d want>=1",
               fall_cnt - f0, min_gap);
    end
    total++;
    if (ready_bad != rb0) begin
      bad++;
      $display("FAIL b2b_tx_ready_low violations=%0d want 0", ready_bad - rb0);
    end
    total++;
    if (mosi_cap !== 8'hFF) begin
      bad++;
      $display("FAIL b2b_mosi_seq got=%h want=ff", mosi_cap);
    end
  endtask

  task automatic test_reset_abort();
    int rx0;
    int xs0;
    rx0 = rx_count;
    xs0 = xfer_started;
    loopback = 1'b1;
    send(8'h96, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 200 && !(xfer_started != xs0 && samp_cnt >= 5); i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({cs_n, tx_ready, busy} !== 3'b110) begin
      bad++;
      $display("FAIL abort_outputs cs_n,tx_ready,busy=%b want 110", {cs_n, tx_ready, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    total++;
    if (rx_count != rx0) begin
      bad++;
      $display("FAIL abort_no_rx_valid pulses=%0d want 0", rx_count - rx0);
    end
    send(8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A);
    wait_rx(rx0 + 1, "after_abort");
    total++;
    if (mosi_cap !== 8'h5A) begin
      bad++;
      $display("FAIL after_abort_mosi_seq got=%h want=5a", mosi_cap);
    end
  endtask

  initial begin : main
    rst_n = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    cpol_in = 1'b0;
    cpha_in = 1'b0;
    test_reset();
    test_mode0();
    test_stray_edges();
    test_mode3();
    test_back_to_back();
    test_reset_abort();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL outstanding_words left=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
